// File: rtl/dmem_io.sv
// Data memory with 256-word RAM, memory-mapped output FIFO, status register and cycle counter.
// Loads are combinational; the FIFO drains on io_valid&io_ready, and stores to a full FIFO are dropped and set ovf.
module dmem_io #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [16:0] aluout,
  input  logic [16:0] writedata,
  output logic [16:0] readdata,
  output logic [16:0] io_data,
  output logic        io_valid,
  input  logic        io_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = 4;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [16:0]   ram_q  [256];
  logic [16:0]   fifo_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [16:0]   cyc_q, cyc_d;

  logic in_ram, sel_fifo, sel_stat, sel_cnt;
  logic full, empty, pop, push_req, push, ovf_set;

  assign in_ram   = (aluout[16:8] == 9'd0);
  assign sel_fifo = (aluout == 17'h00100);
  assign sel_stat = (aluout == 17'h00101);
  assign sel_cnt  = (aluout == 17'h00102);

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign io_valid = !empty;
  assign io_data  = fifo_q[rd_ptr_q];

  // A same-cycle pop frees the slot, so a push into a full FIFO is still accepted.
  assign pop      = io_valid & io_ready;
  assign push_req = memwrite & sel_fifo;
  assign push     = push_req & (!full | pop);
  assign ovf_set  = push_req & full & !pop;

  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q;
    if (memwrite && sel_stat) ovf_d = 1'b0;
    if (ovf_set)              ovf_d = 1'b1;
    cyc_d = (memwrite && sel_cnt) ? writedata : cyc_q + 17'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      cyc_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      cyc_q    <= cyc_d;
    end
  end

  // Storage arrays carry no reset; FIFO entries are only meaningful below count.
  always_ff @(posedge clk) begin
    if (memwrite && in_ram) ram_q[aluout[7:0]] <= writedata;
    if (push && !reset)     fifo_q[wr_ptr_q]   <= writedata;
  end

  always_comb begin
    readdata = '0;
    if (in_ram)        readdata = ram_q[aluout[7:0]];
    else if (sel_fifo) readdata = empty ? 17'd0 : io_data;
    else if (sel_stat) readdata = {10'd0, ovf_q, empty, full, count_q};
    else if (sel_cnt)  readdata = cyc_q;
  end

endmodule

// File: tb/tb_dmem_io.sv
// Directed bench for dmem_io: stimulus pushes expected loads/FIFO words into queues, a negedge monitor compares.
module tb_dmem_io;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwrite = 1'b0;
  logic [16:0] aluout = '0;
  logic [16:0] writedata = '0;
  logic [16:0] readdata;
  logic [16:0] io_data;
  logic        io_valid;
  logic        io_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [16:0] exp_q [$];
  logic [16:0] ld_q  [$];
  string       ld_nm [$];
  logic        ld_chk = 1'b0;
  logic        vld_chk = 1'b0;
  logic        vld_exp = 1'b0;

  dmem_io #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .aluout(aluout),
    .writedata(writedata), .readdata(readdata), .io_data(io_data),
    .io_valid(io_valid), .io_ready(io_ready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic [16:0] e;
    string n;
    if (ld_chk) begin
      checks++;
      if (ld_q.size() == 0) begin
        failures++;
        $display("FAIL load_queue: no expected value queued");
      end else begin
        e = ld_q.pop_front();
        n = ld_nm.pop_front();
        if (readdata !== e) begin
          failures++;
          $display("FAIL %s: readdata=%05h expected=%05h", n, readdata, e);
        end
      end
    end
    if (vld_chk) begin
      checks++;
      if (io_valid !== vld_exp) begin
        failures++;
        $display("FAIL io_valid: got=%0b expected=%0b", io_valid, vld_exp);
      end
    end
    if (!reset && io_valid && io_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pop: io_data=%05h expected=none", io_data);
      end else begin
        e = exp_q.pop_front();
        if (io_data !== e) begin
          failures++;
          $display("FAIL drain: io_data=%05h expected=%05h", io_data, e);
        end
      end
    end
  end

  task automatic step(input logic rst, input logic we, input logic [16:0] addr,
                      input logic [16:0] wd, input logic rdy, input logic chk,
                      input logic [16:0] exp, input string nm);
    reset = rst; memwrite = we; aluout = addr; writedata = wd; io_ready = rdy;
    if (chk) begin
      ld_q.push_back(exp);
      ld_nm.push_back(nm);
    end
    ld_chk = chk;
    @(posedge clk);
    #1;
    ld_chk = 1'b0;
    vld_chk = 1'b0;
  endtask

  task automatic ld(input logic [16:0] addr, input logic [16:0] exp, input string nm);
    step(1'b0, 1'b0, addr, 17'd0, 1'b0, 1'b1, exp, nm);
  endtask

  task automatic st(input logic [16:0] addr, input logic [16:0] wd);
    step(1'b0, 1'b1, addr, wd, 1'b0, 1'b0, 17'd0, "");
  endtask

  // Store to the FIFO; accept says whether this word must later appear at io_data.
  task automatic fpush(input logic [16:0] wd, input logic rdy, input logic accept);
    if (accept) exp_q.push_back(wd);
    step(1'b0, 1'b1, 17'h00100, wd, rdy, 1'b0, 17'd0, "");
  endtask

  task automatic drain();
    for (int i = 0; i < 16 && exp_q.size() != 0; i++)
      step(1'b0, 1'b0, 17'h00000, 17'd0, 1'b1, 1'b0, 17'd0, "");
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: left=%0d expected=0", exp_q.size());
    end
  endtask

  initial begin
    #1;
    step(1'b1, 1'b0, 17'd0, 17'd0, 1'b0, 1'b0, 17'd0, "");
    step(1'b1, 1'b0, 17'd0, 17'd0, 1'b0, 1'b0, 17'd0, "");

    // Reset state
    vld_chk = 1'b1; vld_exp = 1'b0;
    ld(17'h00102, 17'h00000, "reset_counter");
    ld(17'h00101, 17'h00020, "reset_status");

    // RAM: old value on same-cycle load, new value next cycle
    st(17'h00005, 17'h00111);
    step(1'b0, 1'b1, 17'h00005, 17'h1ABCD, 1'b0, 1'b1, 17'h00111, "ram_same_cycle");
    ld(17'h00005, 17'h1ABCD, "ram_next_cycle");
    st(17'h000FF, 17'h15555);
    ld(17'h000FF, 17'h15555, "ram_top_word");
    ld(17'h00005, 17'h1ABCD, "ram_kept");

    // FIFO fill, overflow, clear, full push+pop
    ld(17'h00100, 17'h00000, "fifo_empty_load");
    fpush(17'd1, 1'b0, 1'b1);
    fpush(17'd2, 1'b0, 1'b1);
    fpush(17'd3, 1'b0, 1'b1);
    fpush(17'd4, 1'b0, 1'b1);
    ld(17'h00101, 17'h00014, "status_full");
    ld(17'h00100, 17'h00001, "fifo_head_load");
    ld(17'h00101, 17'h00014, "status_no_pop_side_effect");
    fpush(17'd5, 1'b0, 1'b0);
    ld(17'h00101, 17'h00054, "status_ovf");
    st(17'h00101, 17'h00000);
    ld(17'h00101, 17'h00014, "status_ovf_cleared");
    fpush(17'd9, 1'b1, 1'b1);
    ld(17'h00101, 17'h00014, "status_full_pushpop");
    ld(17'h00100, 17'h00002, "head_advanced");
    drain();
    vld_chk = 1'b1; vld_exp = 1'b0;
    ld(17'h00101, 17'h00020, "status_drained");

    // One entry: simultaneous push+pop makes the pushed word the head
    fpush(17'd7, 1'b0, 1'b1);
    fpush(17'd8, 1'b1, 1'b1);
    ld(17'h00101, 17'h00001, "status_one_entry");
    ld(17'h00100, 17'h00008, "head_one_entry");
    drain();

    // Cycle counter load and wrap
    st(17'h00102, 17'h1FFFE);
    ld(17'h00102, 17'h1FFFE, "counter_loaded");
    ld(17'h00102, 17'h1FFFF, "counter_plus1");
    ld(17'h00102, 17'h00000, "counter_wrap");
    ld(17'h00102, 17'h00001, "counter_after_wrap");

    // Mid-operation reset overrides push/pop and discards contents
    fpush(17'h0000A, 1'b0, 1'b1);
    fpush(17'h0000B, 1'b0, 1'b1);
    exp_q.delete();
    step(1'b1, 1'b1, 17'h00100, 17'h0000C, 1'b1, 1'b0, 17'd0, "");
    vld_chk = 1'b1; vld_exp = 1'b0;
    ld(17'h00102, 17'h00000, "counter_after_reset");
    ld(17'h00101, 17'h00020, "status_after_reset");

    // Unmapped addresses
    st(17'h000F0, 17'h12345);
    st(17'h001F0, 17'h1FFFF);
    ld(17'h001F0, 17'h00000, "unmapped_load");
    ld(17'h00103, 17'h00000, "unmapped_load_103");
    ld(17'h000F0, 17'h12345, "ram_after_unmapped");
    ld(17'h00101, 17'h00020, "status_after_unmapped");

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_fifo: left=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
